// File: rtl/matmul_seq_ctrl_if.sv
// Load / readout / status bundle for matmul_seq_ctrl.
// The master drives operand loads and readout indices; the slave returns result data and status.
interface matmul_seq_ctrl_if #(
    parameter int N      = 2,
    parameter int DATA_W = 8,
    parameter int OUT_W  = 8
);
  localparam int IW = $clog2(N);

  logic              load_en;
  logic              load_sel_ab;
  logic [IW-1:0]     load_row;
  logic [IW-1:0]     load_col;
  logic [DATA_W-1:0] in_data;
  logic              output_en;
  logic [IW-1:0]     out_row;
  logic [IW-1:0]     out_col;
  logic [OUT_W-1:0]  out_data;
  logic              busy;
  logic              done;
  logic              overflow;

  modport master (
    output load_en, load_sel_ab, load_row, load_col, in_data,
    output output_en, out_row, out_col,
    input  out_data, busy, done, overflow
  );

  modport slave (
    input  load_en, load_sel_ab, load_row, load_col, in_data,
    input  output_en, out_row, out_col,
    output out_data, busy, done, overflow
  );
endinterface

// File: rtl/matmul_seq_ctrl.sv
// Sequential N x N matrix multiply (C = A*B) on one MAC unit, with indexed result readout.
// Define MATMUL_SEQ_CTRL_SAT_EN for saturating result reduction; otherwise results are truncated.
module matmul_seq_ctrl #(
    parameter int N      = 2,
    parameter int DATA_W = 8,
    parameter int OUT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  matmul_seq_ctrl_if.slave bus
);
  localparam int IW    = $clog2(N);
  localparam int ACC_W = 2 * DATA_W + $clog2(N);
  localparam logic [IW:0]   N_EXT = (IW + 1)'(N);
  localparam logic [IW-1:0] LAST  = IW'(N - 1);

  typedef enum logic [1:0] {ST_LOAD, ST_COMPUTE, ST_DONE} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] a_q [N][N];
  logic [DATA_W-1:0] a_d [N][N];
  logic [DATA_W-1:0] b_q [N][N];
  logic [DATA_W-1:0] b_d [N][N];
  logic [OUT_W-1:0]  c_q [N][N];
  logic [OUT_W-1:0]  c_d [N][N];
  logic [N-1:0]      a_mask_q [N];
  logic [N-1:0]      a_mask_d [N];
  logic [N-1:0]      b_mask_q [N];
  logic [N-1:0]      b_mask_d [N];
  logic [IW-1:0]     i_q, i_d, j_q, j_d, k_q, k_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic              ovf_q, ovf_d;

  logic [N-1:0]      a_row_full, b_row_full;
  logic              masks_full;
  logic              load_ok, out_ok;
  logic [2*DATA_W-1:0] prod;
  logic [ACC_W-1:0]  sum;
  logic              sum_ovf;
  logic [OUT_W-1:0]  sum_red;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_row_full
      assign a_row_full[gi] = &a_mask_q[gi];
      assign b_row_full[gi] = &b_mask_q[gi];
    end
  endgenerate

  assign masks_full = (&a_row_full) & (&b_row_full);
  assign load_ok = bus.load_en && ({1'b0, bus.load_row} < N_EXT) && ({1'b0, bus.load_col} < N_EXT);
  assign out_ok  = bus.output_en && ({1'b0, bus.out_row} < N_EXT) && ({1'b0, bus.out_col} < N_EXT);

  assign prod = (2*DATA_W)'(a_q[i_q][k_q]) * (2*DATA_W)'(b_q[k_q][j_q]);
  assign sum  = acc_q + ACC_W'(prod);

  generate
    if (ACC_W > OUT_W) begin : g_ovf
      assign sum_ovf = |sum[ACC_W-1:OUT_W];
    end else begin : g_no_ovf
      assign sum_ovf = 1'b0;
    end
  endgenerate

`ifdef MATMUL_SEQ_CTRL_SAT_EN
  assign sum_red = sum_ovf ? {OUT_W{1'b1}} : OUT_W'(sum);
`else
  assign sum_red = OUT_W'(sum);
`endif

  assign bus.out_data = out_ok ? c_q[bus.out_row][bus.out_col] : '0;
  assign bus.busy     = (state_q == ST_COMPUTE);
  assign bus.done     = (state_q == ST_DONE);
  assign bus.overflow = ovf_q;

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    c_d      = c_q;
    a_mask_d = a_mask_q;
    b_mask_d = b_mask_q;
    i_d      = i_q;
    j_d      = j_q;
    k_d      = k_q;
    acc_d    = acc_q;
    ovf_d    = ovf_q;

    // Operands are frozen while the MAC loop is reading them.
    if (load_ok && state_q != ST_COMPUTE) begin
      if (!bus.load_sel_ab) begin
        a_d[bus.load_row][bus.load_col]      = bus.in_data;
        a_mask_d[bus.load_row][bus.load_col] = 1'b1;
      end else begin
        b_d[bus.load_row][bus.load_col]      = bus.in_data;
        b_mask_d[bus.load_row][bus.load_col] = 1'b1;
      end
    end

    case (state_q)
      ST_LOAD: begin
        // Start looks at the registered masks, so a same-cycle load never triggers it.
        if (masks_full) begin
          state_d = ST_COMPUTE;
          for (int r = 0; r < N; r++) begin
            a_mask_d[r] = '0;
            b_mask_d[r] = '0;
          end
          ovf_d = 1'b0;
          i_d   = '0;
          j_d   = '0;
          k_d   = '0;
          acc_d = '0;
        end
      end
      ST_COMPUTE: begin
        if (k_q == LAST) begin
          c_d[i_q][j_q] = sum_red;
          if (sum_ovf) ovf_d = 1'b1;
          acc_d = '0;
          k_d   = '0;
          if (j_q == LAST) begin
            j_d = '0;
            if (i_q == LAST) begin
              i_d     = '0;
              state_d = ST_DONE;
            end else begin
              i_d = i_q + 1'b1;
            end
          end else begin
            j_d = j_q + 1'b1;
          end
        end else begin
          acc_d = sum;
          k_d   = k_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (bus.load_en) state_d = ST_LOAD;
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_LOAD;
      for (int r = 0; r < N; r++) begin
        a_mask_q[r] <= '0;
        b_mask_q[r] <= '0;
        for (int c = 0; c < N; c++) begin
          a_q[r][c] <= '0;
          b_q[r][c] <= '0;
          c_q[r][c] <= '0;
        end
      end
      i_q   <= '0;
      j_q   <= '0;
      k_q   <= '0;
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      c_q      <= c_d;
      a_mask_q <= a_mask_d;
      b_mask_q <= b_mask_d;
      i_q      <= i_d;
      j_q      <= j_d;
      k_q      <= k_d;
      acc_q    <= acc_d;
      ovf_q    <= ovf_d;
    end
  end
endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Scoreboard bench for matmul_seq_ctrl: an N=2 instance and an N=3 (OUT_W=16) instance.
// Stimulus queues expected values; a negedge monitor pops and compares them.
module tb_matmul_seq_ctrl;
  localparam int BUSY_KIND = 1, DONE_KIND = 2, OVF_KIND = 3, RUN_KIND = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       sel = 1'b0;
  logic       ld_en = 1'b0, ld_ab = 1'b0;
  logic [1:0] ld_row = '0, ld_col = '0;
  logic [7:0] ld_data = '0;
  logic       oe = 1'b0;
  logic [1:0] o_row = '0, o_col = '0;
  logic       chk_req = 1'b0;

  matmul_seq_ctrl_if #(.N(2), .DATA_W(8), .OUT_W(8))  if2 ();
  matmul_seq_ctrl_if #(.N(3), .DATA_W(8), .OUT_W(16)) if3 ();

  assign if2.load_en     = ld_en & ~sel;
  assign if2.load_sel_ab = ld_ab;
  assign if2.load_row    = ld_row[0];
  assign if2.load_col    = ld_col[0];
  assign if2.in_data     = ld_data;
  assign if2.output_en   = oe & ~sel;
  assign if2.out_row     = o_row[0];
  assign if2.out_col     = o_col[0];

  assign if3.load_en     = ld_en & sel;
  assign if3.load_sel_ab = ld_ab;
  assign if3.load_row    = ld_row;
  assign if3.load_col    = ld_col;
  assign if3.in_data     = ld_data;
  assign if3.output_en   = oe & sel;
  assign if3.out_row     = o_row;
  assign if3.out_col     = o_col;

  matmul_seq_ctrl #(.N(2), .DATA_W(8), .OUT_W(8))  dut2 (.clk(clk), .rst(rst), .bus(if2.slave));
  matmul_seq_ctrl #(.N(3), .DATA_W(8), .OUT_W(16)) dut3 (.clk(clk), .rst(rst), .bus(if3.slave));

  logic [15:0] m_data;
  logic        m_busy, m_done, m_ovf;
  assign m_data = sel ? if3.out_data : {8'd0, if2.out_data};
  assign m_busy = sel ? if3.busy : if2.busy;
  assign m_done = sel ? if3.done : if2.done;
  assign m_ovf  = sel ? if3.overflow : if2.overflow;

  typedef struct {
    string name;
    int    kind;
    int    exp;
  } chk_t;
  chk_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;
  int run = 0;
  int last_run = 0;

  // Monitor: track busy run length, then drain the scoreboard when a check is requested.
  always @(negedge clk) begin
    chk_t e;
    int act;
    if (m_busy) run++;
    else if (run != 0) begin
      last_run = run;
      run = 0;
    end
    if (chk_req) begin
      while (sb.size() > 0) begin
        e = sb.pop_front();
        case (e.kind)
          BUSY_KIND: act = int'(m_busy);
          DONE_KIND: act = int'(m_done);
          OVF_KIND:  act = int'(m_ovf);
          RUN_KIND:  act = last_run;
          default:   act = int'(m_data);
        endcase
        n_cmp++;
        if (act != e.exp) begin
          n_bad++;
          $display("FAIL %s: got %0d expected %0d", e.name, act, e.exp);
        end else begin
          $display("ok   %s: %0d", e.name, act);
        end
      end
    end
  end

  task automatic chk(string nm, int kind, int exp);
    sb.push_back('{nm, kind, exp});
    chk_req = 1'b1;
    @(posedge clk); #1;
    chk_req = 1'b0;
  endtask

  task automatic rd(string nm, int r, int c, int exp);
    oe = 1'b1;
    o_row = 2'(r);
    o_col = 2'(c);
    chk(nm, 0, exp);
    oe = 1'b0;
  endtask

  task automatic ld(bit ab, int r, int c, int d);
    ld_en = 1'b1;
    ld_ab = ab;
    ld_row = 2'(r);
    ld_col = 2'(c);
    ld_data = 8'(d);
    @(posedge clk); #1;
    ld_en = 1'b0;
  endtask

  task automatic ld_mat2(bit ab, int v00, int v01, int v10, int v11);
    ld(ab, 0, 0, v00);
    ld(ab, 0, 1, v01);
    ld(ab, 1, 0, v10);
    ld(ab, 1, 1, v11);
  endtask

  task automatic wait_done();
    int cnt = 0;
    while (!m_done && cnt < 200) begin
      @(posedge clk); #1;
      cnt++;
    end
    if (!m_done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_done: got done=0 expected 1 within 200 cycles");
    end
  endtask

  task automatic check_basic(string tag);
    rd({tag, "_c00"}, 0, 0, 19);
    rd({tag, "_c01"}, 0, 1, 22);
    rd({tag, "_c10"}, 1, 0, 43);
    rd({tag, "_c11"}, 1, 1, 50);
    chk({tag, "_ovf"}, OVF_KIND, 0);
  endtask

  int exp_ovf_val;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    chk("rst_busy", BUSY_KIND, 0);
    chk("rst_done", DONE_KIND, 0);
    chk("rst_ovf", OVF_KIND, 0);
    rd("rst_c00", 0, 0, 0);
    rd("rst_c11", 1, 1, 0);

    // Basic multiply, B loaded before A
    ld_mat2(1'b1, 5, 6, 7, 8);
    ld_mat2(1'b0, 1, 2, 3, 4);
    chk("basic_busy_t", BUSY_KIND, 0);
    chk("basic_busy_t1", BUSY_KIND, 1);
    wait_done();
    chk("basic_run", RUN_KIND, 8);
    chk("basic_busy_off", BUSY_KIND, 0);
    check_basic("basic");
    o_row = 2'd1; o_col = 2'd1;
    chk("basic_oe0", 0, 0);

    // Reload from DONE, 7 of 8 with a duplicate, then load during compute
    ld(1'b0, 0, 0, 1);
    chk("reload_done_drop", DONE_KIND, 0);
    rd("reload_old_c00", 0, 0, 19);
    ld(1'b0, 0, 1, 2);
    ld(1'b0, 1, 0, 3);
    ld(1'b0, 1, 1, 4);
    ld(1'b1, 0, 0, 5);
    ld(1'b1, 0, 1, 6);
    ld(1'b0, 0, 1, 2);
    ld(1'b1, 1, 0, 7);
    chk("reload7_busy_a", BUSY_KIND, 0);
    chk("reload7_busy_b", BUSY_KIND, 0);
    chk("reload7_busy_c", BUSY_KIND, 0);
    ld(1'b1, 1, 1, 8);
    chk("reload8_busy_t", BUSY_KIND, 0);
    chk("reload8_busy_t1", BUSY_KIND, 1);
    ld(1'b0, 0, 0, 9);
    wait_done();
    chk("midload_run", RUN_KIND, 8);
    check_basic("midload");

    // Masks must be clear after the run: all but A[0][0] never starts
    ld(1'b0, 0, 1, 2);
    ld(1'b0, 1, 0, 3);
    ld(1'b0, 1, 1, 4);
    ld_mat2(1'b1, 5, 6, 7, 8);
    chk("mask_clear_busy_a", BUSY_KIND, 0);
    chk("mask_clear_busy_b", BUSY_KIND, 0);
    ld(1'b0, 0, 0, 1);
    wait_done();
    check_basic("mask_clear");

    // Overflow: every sum is 130050
`ifdef MATMUL_SEQ_CTRL_SAT_EN
    exp_ovf_val = 255;
`else
    exp_ovf_val = 2;
`endif
    ld_mat2(1'b0, 255, 255, 255, 255);
    ld_mat2(1'b1, 255, 255, 255, 255);
    wait_done();
    rd("ovf_c00", 0, 0, exp_ovf_val);
    rd("ovf_c01", 0, 1, exp_ovf_val);
    rd("ovf_c10", 1, 0, exp_ovf_val);
    rd("ovf_c11", 1, 1, exp_ovf_val);
    chk("ovf_flag", OVF_KIND, 1);

    // Reset mid-compute
    ld_mat2(1'b0, 1, 2, 3, 4);
    ld_mat2(1'b1, 5, 6, 7, 8);
    chk("rstmid_busy_t", BUSY_KIND, 0);
    chk("rstmid_busy_t1", BUSY_KIND, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rstmid_busy", BUSY_KIND, 0);
    chk("rstmid_done", DONE_KIND, 0);
    chk("rstmid_ovf", OVF_KIND, 0);
    rd("rstmid_c00", 0, 0, 0);
    rd("rstmid_c01", 0, 1, 0);
    rd("rstmid_c10", 1, 0, 0);
    rd("rstmid_c11", 1, 1, 0);
    ld_mat2(1'b0, 1, 2, 3, 4);
    ld_mat2(1'b1, 5, 6, 7, 8);
    wait_done();
    chk("after_rst_run", RUN_KIND, 8);
    check_basic("after_rst");

    // N=3: identity times [1..9]
    sel = 1'b1;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        ld(1'b0, r, c, (r == c) ? 1 : 0);
        ld(1'b1, r, c, r * 3 + c + 1);
      end
    wait_done();
    chk("n3_run", RUN_KIND, 27);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        rd($sformatf("n3_c%0d%0d", r, c), r, c, r * 3 + c + 1);
    rd("n3_oob_row", 3, 0, 0);
    chk("n3_ovf", OVF_KIND, 0);

    @(posedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/matmul_seq_ctrl.md
# matmul_seq_ctrl

Parametrised successor to the 2x2 matrix controller. Accepts two N×N operand matrices element by element, starts automatically once every element of both is loaded, and computes C = A·B on a single internal multiply-accumulate unit. It then holds the result for indexed readout and flags done. C elements are reduced to OUT_W bits, with an optional saturating mode and a sticky overflow flag.

## Interface
Parameters:
- N, 2, matrix dimension (N ≥ 2)
- DATA_W, 8, unsigned operand width
- OUT_W, 8, result width presented on out_data
- Derived (localparam): IW = $clog2(N); ACC_W = 2·DATA_W + $clog2(N)

Ports:
- clk  in  1  single clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- load_en  in  1  write in_data into the selected operand element this cycle
- load_sel_ab  in  1  0 = A, 1 = B
- load_row  in  IW  element row
- load_col  in  IW  element column
- in_data  in  DATA_W  operand value
- output_en  in  1  enable result readout
- out_row  in  IW  result row
- out_col  in  IW  result column
- out_data  out  OUT_W  C[out_row][out_col] when output_en, else 0
- busy  out  1  high while COMPUTE
- done  out  1  high while DONE
- overflow  out  1  sticky: some C element exceeded OUT_W

## Operation
- States: LOAD (reset state), COMPUTE, DONE.
- Masks a_loaded and b_loaded are N·N bits each. A load in LOAD or DONE writes the element and sets its mask bit.
  - A load with row ≥ N or col ≥ N is ignored.
  - Loads during COMPUTE are ignored: no write, no mask change.
- LOAD→COMPUTE: the registered masks are both all-ones. On the transition: masks clear, overflow clears, loop counters i, j, k = 0, accumulator = 0.
- COMPUTE runs one MAC per cycle with loop order i (outer), j, k (inner): acc += A[i][k]·B[k][j] at full ACC_W width, with no internal overflow.
  - At k = N−1, the reduced value of the final sum is written to C[i][j] and acc resets.
  - After i = j = k = N−1, the state moves to DONE.
- DONE holds C and done = 1. The first load_en in DONE performs its write and moves the state to LOAD, which clears done.
  - Unwritten operands keep their old values, but their mask bits are clear, so the next compute needs all 2·N² elements reloaded.
- Reduction of a sum to OUT_W bits is set by the macro below. overflow is set whenever the sum ≥ 2^OUT_W.
- out_data is combinational from the C registers. It is 0 when output_en = 0 or when the index is ≥ N. It is valid in any state, and during COMPUTE it shows partially updated C.
- Reset values: A, B, C, the masks, and the acc/counters are all 0. State = LOAD. busy = done = overflow = 0, so out_data = 0.
- rst in any state, including mid-COMPUTE, aborts the operation and restores the reset values on the next edge.

## Timing
- Edge t: the load completing both masks is registered.
- Edge t+1: state becomes COMPUTE and busy = 1.
- busy stays high for exactly N³ cycles. The first MAC happens on edge t+2.
- C[i][j] updates on the edge of its k = N−1 MAC.
- done rises on the same edge busy falls, N³ cycles after busy rose. busy and done are never both high.
- A load of an already-set element does not re-trigger anything. Start fires only on the edge after the last missing bit is set.
- Simultaneous load_en and a start condition in LOAD: the load is taken and the start evaluates the pre-edge masks.
- Readout has zero latency: out_data follows out_row/out_col combinationally.

## Configuration
- MATMUL_SEQ_CTRL_SAT_EN
  - Defined: C[i][j] = min(sum, 2^OUT_W − 1), i.e. saturating.
  - Undefined: C[i][j] = sum[OUT_W−1:0], i.e. truncating.
  - overflow behaves identically in both builds.

## Test plan
- Basic multiply (N=2, DATA_W=8, OUT_W=8). Load A=[1 2;3 4] and B=[5 6;7 8] in any order. Required:
  - busy = 1 for 8 cycles, then done = 1.
  - Readout gives C = [19 22;43 50] and overflow = 0.
  - out_data = 0 whenever output_en = 0.
- Overflow (N=2). Load all elements 255, so each sum is 130050. Required:
  - SAT_EN defined: every C element reads 255.
  - SAT_EN undefined: every C element reads 2.
  - overflow = 1 in both builds.
- Loads during COMPUTE. Attempt to overwrite A[0][0] = 9 mid-run. Required: results identical to the basic multiply, and the masks stay clear after the run.
- Reset mid-compute. Assert rst for 1 cycle at COMPUTE cycle 3. Required:
  - Next cycle: busy = done = overflow = 0, and all C elements read 0.
  - A subsequent full reload computes correctly.
- Reload from DONE. Load the first A element. Required:
  - done drops on the next edge and old C stays readable.
  - Reloading 7 of the 8 elements, including duplicates, never starts a compute.
  - The 8th element starts it.
- N=3 (OUT_W=16) with A = identity and B = [1..9]. Required: busy for 27 cycles, and C equals B.
